// File: rtl/ramdisk_seq_ctl.sv
// RAM-disk sequencer: shares one SRAM between CPU data-port accesses and a
// background block-fill engine, one SRAM cycle per 6502 slot.
`timescale 1ns/1ps

module ramdisk_seq_ctl #(
  parameter int BLKW = 11,
  parameter int AW   = 20
) (
  input  logic          C7M,
  input  logic          nRES,
  input  logic          slot,
  input  logic          cpu_acc,
  input  logic          cpu_wr,
  input  logic          reg_wr,
  input  logic [2:0]    reg_sel,
  input  logic [7:0]    reg_d,
  output logic [AW-1:0] ram_a,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [7:0]    ram_d,
  output logic          cpu_grant,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic {IDLE, FILL} state_t;

  localparam logic [1:0] OP_ABORT = 2'b00;
  localparam logic [1:0] OP_SEEK  = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;
  localparam int RW = 18;
  localparam logic [BLKW:0] BLK_LIMIT = {1'b1, {BLKW{1'b0}}};

  state_t          state, state_next;
  logic [BLKW-1:0] blk;
  logic [7:0]      count;
  logic [7:0]      pat;
  logic [AW-1:0]   cptr;
  logic [AW-1:0]   fptr;
  logic [RW-1:0]   remaining;
  logic [8:0]      n_blocks;
  logic [BLKW:0]   blk_sum;
  logic            range_ok;
  logic            cmd_wr;
  logic [1:0]      op;
  logic            cpu_slot;
  logic            fill_slot;
  logic            last_write;
  logic            seek;
  logic            start_fill;
  logic            abort;
  logic            set_err;

  // COUNT of zero stands for a full 256-block fill
  assign n_blocks   = (count == 8'd0) ? 9'd256 : {1'b0, count};
  assign blk_sum    = {1'b0, blk} + (BLKW+1)'(n_blocks);
  assign range_ok   = (blk_sum <= BLK_LIMIT);
  assign cmd_wr     = reg_wr && (reg_sel == 3'd4);
  assign op         = reg_d[1:0];
  assign cpu_slot   = slot && cpu_acc;
  assign fill_slot  = slot && !cpu_acc && (state == FILL);
  assign last_write = fill_slot && (remaining == RW'(1));

  always_ff @(posedge C7M or negedge nRES) begin
    if (!nRES) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    seek       = 1'b0;
    start_fill = 1'b0;
    abort      = 1'b0;
    set_err    = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_wr) begin
          case (op)
            OP_SEEK: seek = 1'b1;
            OP_FILL: begin
              if (range_ok) begin
                start_fill = 1'b1;
                state_next = FILL;
              end else begin
                set_err = 1'b1;
              end
            end
            OP_RSVD: set_err = 1'b1;
            default: ;
          endcase
        end
      end
      FILL: begin
        if (cmd_wr && (op == OP_ABORT)) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else begin
          if (cmd_wr) set_err = 1'b1;
          if (last_write) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A SEEK landing on a CPU slot wins over the post-access increment
  always_ff @(posedge C7M or negedge nRES) begin
    if (!nRES) begin
      blk       <= '0;
      count     <= '0;
      pat       <= '0;
      cptr      <= '0;
      fptr      <= '0;
      remaining <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (reg_wr && (state == IDLE)) begin
        case (reg_sel)
          3'd0:    blk[7:0]      <= reg_d;
          3'd1:    blk[BLKW-1:8] <= reg_d[BLKW-9:0];
          3'd2:    count         <= reg_d;
          3'd3:    pat           <= reg_d;
          default: ;
        endcase
      end
      if (seek)          cptr <= {blk, 9'b0};
      else if (cpu_slot) cptr <= cptr + AW'(1);
      if (start_fill) begin
        fptr      <= {blk, 9'b0};
        remaining <= {n_blocks, 9'b0};
      end else if (fill_slot) begin
        fptr      <= fptr + AW'(1);
        remaining <= remaining - RW'(1);
      end
      if (abort)           done <= 1'b0;
      else if (last_write) done <= 1'b1;
      else if (cmd_wr)     done <= 1'b0;
      if (set_err)     err <= 1'b1;
      else if (cmd_wr) err <= 1'b0;
    end
  end

  // SRAM strobes are one-cycle pulses following the slot; address holds between them
  always_ff @(posedge C7M or negedge nRES) begin
    if (!nRES) begin
      ram_a     <= '0;
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      cpu_grant <= 1'b0;
    end else if (cpu_slot) begin
      ram_a     <= cptr;
      ram_cs    <= 1'b1;
      ram_we    <= cpu_wr;
      cpu_grant <= 1'b1;
    end else if (fill_slot) begin
      ram_a     <= fptr;
      ram_cs    <= 1'b1;
      ram_we    <= 1'b1;
      cpu_grant <= 1'b0;
    end else begin
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      cpu_grant <= 1'b0;
    end
  end

  assign busy  = (state == FILL);
  assign ram_d = pat;

endmodule

// File: tb/tb_ramdisk_seq_ctl.sv
// Bench for ramdisk_seq_ctl: vector table, multi-cycle fill/abort/reset
// sequences and random traffic, all checked against a behavioural model.
`timescale 1ns/1ps

module tb_ramdisk_seq_ctl;

  localparam int BLKW     = 11;
  localparam int AW       = 20;
  localparam int ADDR_MOD = 1 << AW;
  localparam int BLOCKS   = 1 << BLKW;
  localparam int NVEC     = 26;

  logic          C7M = 1'b0;
  logic          nRES = 1'b1;
  logic          slot = 1'b0;
  logic          cpu_acc = 1'b0;
  logic          cpu_wr = 1'b0;
  logic          reg_wr = 1'b0;
  logic [2:0]    reg_sel = 3'd0;
  logic [7:0]    reg_d = 8'd0;
  logic [AW-1:0] ram_a;
  logic          ram_cs;
  logic          ram_we;
  logic [7:0]    ram_d;
  logic          cpu_grant;
  logic          busy;
  logic          done;
  logic          err;

  int n_cmp  = 0;
  int n_fail = 0;

  bit m_busy, m_done, m_err, m_cs, m_we, m_grant;
  int m_blk, m_count, m_pat, m_cptr, m_fptr, m_left, m_a;

  typedef struct {
    logic          rw;
    logic [2:0]    sel;
    logic [7:0]    d;
    logic          sl;
    logic          acc;
    logic          wr;
    logic [AW-1:0] ea;
    logic          ecs;
    logic          ewe;
    logic          egr;
    logic          ebusy;
    logic          edone;
    logic          eerr;
    logic [7:0]    ed;
  } vec_t;

  vec_t tbl [NVEC];

  always #5 C7M = ~C7M;

  ramdisk_seq_ctl #(.BLKW(BLKW), .AW(AW)) dut (
    .C7M(C7M), .nRES(nRES), .slot(slot), .cpu_acc(cpu_acc), .cpu_wr(cpu_wr),
    .reg_wr(reg_wr), .reg_sel(reg_sel), .reg_d(reg_d), .ram_a(ram_a),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_d(ram_d), .cpu_grant(cpu_grant),
    .busy(busy), .done(done), .err(err)
  );

  function automatic logic [33:0] act_bundle();
    return {ram_a, ram_cs, ram_we, ram_d, cpu_grant, busy, done, err};
  endfunction

  function automatic logic [33:0] exp_bundle();
    logic [31:0] a;
    logic [31:0] p;
    a = m_a;
    p = m_pat;
    return {a[AW-1:0], m_cs, m_we, p[7:0], m_grant, m_busy, m_done, m_err};
  endfunction

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_err = 0; m_cs = 0; m_we = 0; m_grant = 0;
    m_blk = 0; m_count = 0; m_pat = 0; m_cptr = 0; m_fptr = 0; m_left = 0; m_a = 0;
  endtask

  // Expected effect of the coming clock edge, computed from current inputs
  task automatic model_edge();
    bit cmd, busy0, finished;
    int op, n, d;
    cmd = reg_wr && (reg_sel == 3'd4);
    d = int'(reg_d);
    op = d & 3;
    busy0 = m_busy;
    finished = 0;
    m_cs = 0; m_we = 0; m_grant = 0;
    if (slot && cpu_acc) begin
      m_cs = 1; m_we = cpu_wr; m_grant = 1; m_a = m_cptr;
      m_cptr = (m_cptr + 1) % ADDR_MOD;
    end else if (slot && busy0) begin
      m_cs = 1; m_we = 1; m_a = m_fptr;
      m_fptr = (m_fptr + 1) % ADDR_MOD;
      m_left = m_left - 1;
      if (m_left == 0) finished = 1;
    end
    if (finished) begin
      m_busy = 0;
      m_done = 1;
    end
    if (reg_wr && !busy0) begin
      case (reg_sel)
        3'd0: m_blk = (m_blk & 'h700) | d;
        3'd1: m_blk = (m_blk & 'hFF) | ((d & 7) << 8);
        3'd2: m_count = d;
        3'd3: m_pat = d;
        default: ;
      endcase
    end
    if (cmd) begin
      if (busy0) begin
        if (op == 0) begin
          m_busy = 0; m_done = 0; m_err = 0;
        end else begin
          m_err = 1;
        end
      end else begin
        m_done = 0;
        m_err = 0;
        if (op == 1) m_cptr = m_blk * 512;
        else if (op == 2) begin
          n = (m_count == 0) ? 256 : m_count;
          if (m_blk + n > BLOCKS) m_err = 1;
          else begin
            m_busy = 1;
            m_fptr = m_blk * 512;
            m_left = n * 512;
          end
        end else if (op == 3) m_err = 1;
      end
    end
  endtask

  task automatic check_output(input string name);
    check_val(name, act_bundle(), exp_bundle());
  endtask

  task automatic apply_stimulus(input logic rw, input logic [2:0] sel, input logic [7:0] d,
                                input logic sl, input logic acc, input logic wr);
    reg_wr = rw; reg_sel = sel; reg_d = d; slot = sl; cpu_acc = acc; cpu_wr = wr;
    model_edge();
    @(posedge C7M);
    #1;
    check_output("model");
  endtask

  task automatic reg_write(input logic [2:0] sel, input logic [7:0] d);
    apply_stimulus(1'b1, sel, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic quiet();
    apply_stimulus(1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reg_wr = 0; reg_sel = 0; reg_d = 0; slot = 0; cpu_acc = 0; cpu_wr = 0;
    nRES = 1'b0;
    #1;
    model_reset();
    check_val("reset_outputs", act_bundle(), 34'd0);
    @(negedge C7M);
    nRES = 1'b1;
  endtask

  task automatic set_vec(input int i, input logic rw, input logic [2:0] sel, input logic [7:0] d,
                         input logic sl, input logic acc, input logic wr, input logic [AW-1:0] ea,
                         input logic ecs, input logic ewe, input logic egr, input logic ebusy,
                         input logic edone, input logic eerr, input logic [7:0] ed);
    tbl[i] = '{rw, sel, d, sl, acc, wr, ea, ecs, ewe, egr, ebusy, edone, eerr, ed};
  endtask

  initial begin
    int writes, bad, slots, cpu_cycles;
    logic acc;
    logic sl;
    logic rw;
    logic [2:0] sel;
    logic [7:0] d;

    //          rw sel d      sl acc wr  ea        cs we gr bsy dn er ed
    set_vec( 0, 1, 0, 8'h05, 0, 0, 0, 20'h00000, 0, 0, 0, 0, 0, 0, 8'h00);
    set_vec( 1, 1, 1, 8'h00, 0, 0, 0, 20'h00000, 0, 0, 0, 0, 0, 0, 8'h00);
    set_vec( 2, 1, 4, 8'h01, 0, 0, 0, 20'h00000, 0, 0, 0, 0, 0, 0, 8'h00);
    set_vec( 3, 0, 0, 8'h00, 1, 1, 1, 20'h00A00, 1, 1, 1, 0, 0, 0, 8'h00);
    set_vec( 4, 0, 0, 8'h00, 0, 0, 0, 20'h00A00, 0, 0, 0, 0, 0, 0, 8'h00);
    set_vec( 5, 0, 0, 8'h00, 1, 1, 1, 20'h00A01, 1, 1, 1, 0, 0, 0, 8'h00);
    set_vec( 6, 0, 0, 8'h00, 1, 1, 1, 20'h00A02, 1, 1, 1, 0, 0, 0, 8'h00);
    set_vec( 7, 0, 0, 8'h00, 1, 1, 0, 20'h00A03, 1, 0, 1, 0, 0, 0, 8'h00);
    set_vec( 8, 1, 0, 8'hFF, 0, 0, 0, 20'h00A03, 0, 0, 0, 0, 0, 0, 8'h00);
    set_vec( 9, 1, 1, 8'hFF, 0, 0, 0, 20'h00A03, 0, 0, 0, 0, 0, 0, 8'h00);
    set_vec(10, 1, 2, 8'h02, 0, 0, 0, 20'h00A03, 0, 0, 0, 0, 0, 0, 8'h00);
    set_vec(11, 1, 4, 8'h02, 0, 0, 0, 20'h00A03, 0, 0, 0, 0, 0, 1, 8'h00);
    set_vec(12, 0, 0, 8'h00, 1, 0, 0, 20'h00A03, 0, 0, 0, 0, 0, 1, 8'h00);
    set_vec(13, 1, 2, 8'h01, 0, 0, 0, 20'h00A03, 0, 0, 0, 0, 0, 1, 8'h00);
    set_vec(14, 1, 3, 8'hE5, 0, 0, 0, 20'h00A03, 0, 0, 0, 0, 0, 1, 8'hE5);
    set_vec(15, 1, 4, 8'h03, 0, 0, 0, 20'h00A03, 0, 0, 0, 0, 0, 1, 8'hE5);
    set_vec(16, 1, 4, 8'h00, 0, 0, 0, 20'h00A03, 0, 0, 0, 0, 0, 0, 8'hE5);
    set_vec(17, 1, 4, 8'h02, 0, 0, 0, 20'h00A03, 0, 0, 0, 1, 0, 0, 8'hE5);
    set_vec(18, 1, 4, 8'h01, 0, 0, 0, 20'h00A03, 0, 0, 0, 1, 0, 1, 8'hE5);
    set_vec(19, 0, 0, 8'h00, 1, 0, 0, 20'hFFE00, 1, 1, 0, 1, 0, 1, 8'hE5);
    set_vec(20, 1, 4, 8'h00, 0, 0, 0, 20'hFFE00, 0, 0, 0, 0, 0, 0, 8'hE5);
    set_vec(21, 0, 0, 8'h00, 1, 0, 0, 20'hFFE00, 0, 0, 0, 0, 0, 0, 8'hE5);
    set_vec(22, 1, 3, 8'h3C, 0, 0, 0, 20'hFFE00, 0, 0, 0, 0, 0, 0, 8'h3C);
    set_vec(23, 1, 4, 8'h02, 0, 0, 0, 20'hFFE00, 0, 0, 0, 1, 0, 0, 8'h3C);
    set_vec(24, 1, 3, 8'hAA, 0, 0, 0, 20'hFFE00, 0, 0, 0, 1, 0, 0, 8'h3C);
    set_vec(25, 1, 4, 8'h00, 0, 0, 0, 20'hFFE00, 0, 0, 0, 0, 0, 0, 8'h3C);

    #2;
    do_reset();

    for (int i = 0; i < NVEC; i++) begin
      apply_stimulus(tbl[i].rw, tbl[i].sel, tbl[i].d, tbl[i].sl, tbl[i].acc, tbl[i].wr);
      check_val($sformatf("vec%0d", i), act_bundle(),
                {tbl[i].ea, tbl[i].ecs, tbl[i].ewe, tbl[i].ed, tbl[i].egr,
                 tbl[i].ebusy, tbl[i].edone, tbl[i].eerr});
    end

    // Top block, one-block fill of 0xE5 ending at the last SRAM byte
    do_reset();
    reg_write(3'd0, 8'hFF);
    reg_write(3'd1, 8'h07);
    reg_write(3'd2, 8'h01);
    reg_write(3'd3, 8'hE5);
    reg_write(3'd4, 8'h02);
    writes = 0; bad = 0; slots = 0;
    while (busy && slots < 1100) begin
      apply_stimulus(1'b0, 3'd0, 8'd0, 1'b1, 1'b0, 1'b0);
      slots++;
      if (ram_cs && ram_we && !cpu_grant) begin
        if (ram_a != AW'(32'hFFE00 + writes) || ram_d != 8'hE5) bad++;
        writes++;
      end
      quiet();
    end
    check_val("fill512_writes", writes, 512);
    check_val("fill512_order", bad, 0);
    check_val("fill512_last_addr", ram_a, 20'hFFFFF);
    check_val("fill512_busy", busy, 0);
    check_val("fill512_done", done, 1);

    // Fill interleaved with CPU reads on every other slot
    do_reset();
    reg_write(3'd0, 8'h23);
    reg_write(3'd1, 8'h01);
    reg_write(3'd2, 8'h01);
    reg_write(3'd3, 8'h5A);
    reg_write(3'd4, 8'h02);
    writes = 0; bad = 0; slots = 0; cpu_cycles = 0;
    while (busy && slots < 2100) begin
      acc = (slots % 2 == 0);
      apply_stimulus(1'b0, 3'd0, 8'd0, 1'b1, acc, 1'b0);
      slots++;
      if (!ram_cs || cpu_grant != acc) bad++;
      if (ram_cs && cpu_grant) cpu_cycles++;
      if (ram_cs && !cpu_grant) begin
        if (ram_a != AW'(32'h24600 + writes) || !ram_we) bad++;
        writes++;
      end
      quiet();
    end
    check_val("mix_slots", slots, 1024);
    check_val("mix_fill_writes", writes, 512);
    check_val("mix_cpu_cycles", cpu_cycles, 512);
    check_val("mix_order", bad, 0);
    check_val("mix_done", done, 1);

    // Abort after ten fill writes
    do_reset();
    reg_write(3'd0, 8'h10);
    reg_write(3'd2, 8'h04);
    reg_write(3'd4, 8'h02);
    writes = 0;
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b0, 3'd0, 8'd0, 1'b1, 1'b0, 1'b0);
      if (ram_cs && ram_we) writes++;
      quiet();
    end
    check_val("abort_writes", writes, 10);
    check_val("abort_last_addr", ram_a, 20'h02009);
    reg_write(3'd4, 8'h00);
    check_val("abort_flags", {busy, done, err}, 3'b000);
    apply_stimulus(1'b0, 3'd0, 8'd0, 1'b1, 1'b0, 1'b0);
    check_val("abort_no_cycle", ram_cs, 0);

    // Asynchronous reset in the middle of a fill
    do_reset();
    reg_write(3'd0, 8'h40);
    reg_write(3'd2, 8'h02);
    reg_write(3'd4, 8'h02);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 3'd0, 8'd0, 1'b1, 1'b0, 1'b0);
    check_val("pre_reset_cs", ram_cs, 1);
    #2;
    nRES = 1'b0;
    slot = 1'b0;
    #1;
    check_val("midfill_reset", act_bundle(), 34'd0);
    model_reset();
    @(negedge C7M);
    nRES = 1'b1;
    apply_stimulus(1'b0, 3'd0, 8'd0, 1'b1, 1'b0, 1'b0);
    check_val("post_reset_no_cycle", {ram_cs, busy}, 2'b00);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      sl  = ($urandom_range(0, 2) == 0);
      acc = sl && ($urandom_range(0, 2) == 0);
      rw  = ($urandom_range(0, 7) == 0);
      sel = 3'($urandom_range(0, 7));
      d   = 8'($urandom);
      if (sel == 3'd2) d = 8'($urandom_range(1, 4));
      apply_stimulus(rw, sel, d, sl, acc, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
